// File: rtl/msi_vector_arbiter.sv
// MSI vector scheduler: latches interrupt rising edges as pending bits, round-robin
// arbitrates them onto the core's msi_request/msi_grant handshake, or drives INTx in legacy mode.
module msi_vector_arbiter #(
    parameter int    SOURCES        = 8,
    parameter int    REPEAT_TIMEOUT = 65535,
    parameter string REPEAT_ENABLE  = "FALSE"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] intr_in,
    input  logic               msi_enable,
    input  logic [2:0]         msi_width,
    input  logic               msi_grant,
    output logic               msi_request,
    output logic [4:0]         msi_vector,
    output logic               intx_assert,
    output logic [SOURCES-1:0] pending
);

    localparam bit REP_ON = (REPEAT_ENABLE == "TRUE");

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t             state_q;
    logic [SOURCES-1:0] prev_q;
    logic [SOURCES-1:0] pending_q;
    logic [SOURCES-1:0] pending_d;
    logic [SOURCES-1:0] rise;
    logic [SOURCES-1:0] clr;
    logic [SOURCES-1:0] rep_set;
    logic [4:0]         ptr_q;
    logic [4:0]         sel_q;
    logic [4:0]         vec_q;
    logic               req_q;
    logic               intx_q;
    logic               grant_hit;
    logic               found;
    logic [4:0]         pick;
    logic [2:0]         eff_width;
    logic [4:0]         mask;

    assign rise      = intr_in & ~prev_q;
    assign grant_hit = (state_q == ST_REQ) && msi_grant && msi_enable;
    assign eff_width = (msi_width > 3'd5) ? 3'd5 : msi_width;
    assign mask      = 5'((6'd1 << eff_width) - 6'd1);

    always_comb begin
        clr = '0;
        for (int i = 0; i < SOURCES; i++) begin
            clr[i] = grant_hit && (sel_q == 5'(i));
        end
    end

    // A rise in the grant cycle is ORed in after the clear, so it survives.
    always_comb begin
        if (!msi_enable) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~clr) | rise | rep_set;
        end
    end

    // Lowest set bit at or above ptr_q, else lowest set bit overall (wraparound).
    always_comb begin
        found = 1'b0;
        pick  = 5'd0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (pending_q[i] && (5'(i) >= ptr_q)) begin
                found = 1'b1;
                pick  = 5'(i);
            end
        end
        if (!found) begin
            for (int i = SOURCES - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    found = 1'b1;
                    pick  = 5'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            ptr_q     <= 5'd0;
            sel_q     <= 5'd0;
            vec_q     <= 5'd0;
            req_q     <= 1'b0;
            intx_q    <= 1'b0;
        end else begin
            prev_q    <= intr_in;
            pending_q <= pending_d;
            if (!msi_enable) begin
                state_q <= ST_IDLE;
                req_q   <= 1'b0;
                intx_q  <= |intr_in;
            end else begin
                intx_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (found) begin
                            sel_q   <= pick;
                            vec_q   <= pick & mask;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (msi_grant) begin
                            req_q   <= 1'b0;
                            ptr_q   <= (sel_q == 5'(SOURCES - 1)) ? 5'd0 : sel_q + 5'd1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        if (REP_ON) begin : g_rep
            localparam int TW = $clog2(REPEAT_TIMEOUT + 1);
            logic [TW-1:0] timer_q [SOURCES];

            // Counts cycles a source sits high but unpending; reaching the timeout re-raises it.
            always_ff @(posedge clk) begin
                for (int i = 0; i < SOURCES; i++) begin
                    if (rst) begin
                        timer_q[i] <= '0;
                    end else if (clr[i] || (timer_q[i] == TW'(REPEAT_TIMEOUT))) begin
                        timer_q[i] <= '0;
                    end else if (intr_in[i] && !pending_q[i]) begin
                        timer_q[i] <= timer_q[i] + TW'(1);
                    end
                end
            end

            always_comb begin
                rep_set = '0;
                for (int i = 0; i < SOURCES; i++) begin
                    rep_set[i] = (timer_q[i] == TW'(REPEAT_TIMEOUT));
                end
            end
        end else begin : g_norep
            assign rep_set = '0;
        end
    endgenerate

    assign msi_request = req_q;
    assign msi_vector  = vec_q;
    assign intx_assert = intx_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_msi_vector_arbiter.sv
// Directed bench: table of burst/width records for an 8-source arbiter, hand sequences for
// grant-cycle rises, legacy INTx, enable drop, and a 32-source instance with repeat timers.
module tb_msi_vector_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-source instance, repeat disabled
    logic       rst, en, grant, req, intx;
    logic [7:0] intr, pend;
    logic [2:0] width;
    logic [4:0] vec;

    // 32-source instance, repeat enabled with a short timeout
    logic        r_rst, r_en, r_grant, r_req, r_intx;
    logic [31:0] r_intr, r_pend;
    logic [2:0]  r_width;
    logic [4:0]  r_vec;

    int n_cmp = 0;
    int n_err = 0;

    msi_vector_arbiter #(.SOURCES(8)) u_dut (
        .clk(clk), .rst(rst), .intr_in(intr), .msi_enable(en), .msi_width(width),
        .msi_grant(grant), .msi_request(req), .msi_vector(vec), .intx_assert(intx),
        .pending(pend)
    );

    msi_vector_arbiter #(.SOURCES(32), .REPEAT_TIMEOUT(16), .REPEAT_ENABLE("TRUE")) u_rep (
        .clk(clk), .rst(r_rst), .intr_in(r_intr), .msi_enable(r_en), .msi_width(r_width),
        .msi_grant(r_grant), .msi_request(r_req), .msi_vector(r_vec), .intx_assert(r_intx),
        .pending(r_pend)
    );

    typedef struct {
        bit         do_rst;
        logic [7:0] intr;
        logic [2:0] width;
        int         n;
        logic [4:0] v0, v1, v2, v3;
    } rec_t;

    rec_t recs [8];

    function automatic rec_t mk(input bit r, input logic [7:0] m, input logic [2:0] w,
                                input int n, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [4:0] d);
        rec_t t;
        t.do_rst = r; t.intr = m; t.width = w; t.n = n;
        t.v0 = a; t.v1 = b; t.v2 = c; t.v3 = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; intr = '0; grant = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        intr = m; step(); intr = '0;
    endtask

    task automatic run_rec(input rec_t r);
        logic [4:0] ev;
        if (r.do_rst) do_reset();
        en = 1'b1; width = r.width;
        intr = r.intr; step(); intr = '0;
        chk("pend_capture", pend, r.intr);
        chk("req_not_yet", req, 1'b0);
        for (int j = 0; j < r.n; j++) begin
            ev = (j == 0) ? r.v0 : (j == 1) ? r.v1 : (j == 2) ? r.v2 : r.v3;
            step();
            chk("req_on", req, 1'b1);
            chk("req_vector", vec, ev);
            step();
            chk("req_held", req, 1'b1);
            chk("vec_held", vec, ev);
            grant = 1'b1; step(); grant = 1'b0;
            chk("req_drop_after_grant", req, 1'b0);
        end
        step(); step();
        chk("no_extra_req", req, 1'b0);
        chk("pend_empty", pend, 8'h00);
    endtask

    initial begin : main
        int cnt;
        recs[0] = mk(1'b1, 8'h08, 3'd3, 1, 5'd3, 5'd0, 5'd0, 5'd0);
        recs[1] = mk(1'b1, 8'h25, 3'd3, 3, 5'd0, 5'd2, 5'd5, 5'd0);
        recs[2] = mk(1'b1, 8'hC0, 3'd1, 2, 5'd0, 5'd1, 5'd0, 5'd0);
        recs[3] = mk(1'b1, 8'hC0, 3'd0, 2, 5'd0, 5'd0, 5'd0, 5'd0);
        recs[4] = mk(1'b1, 8'h90, 3'd2, 2, 5'd0, 5'd3, 5'd0, 5'd0);
        recs[5] = mk(1'b1, 8'h40, 3'd3, 1, 5'd6, 5'd0, 5'd0, 5'd0);
        recs[6] = mk(1'b0, 8'h81, 3'd3, 2, 5'd7, 5'd0, 5'd0, 5'd0);
        recs[7] = mk(1'b0, 8'h03, 3'd3, 2, 5'd1, 5'd0, 5'd0, 5'd0);

        en = 1'b1; width = 3'd3; intr = '0; grant = 1'b0;
        r_rst = 1'b1; r_en = 1'b1; r_width = 3'd3; r_intr = '0; r_grant = 1'b0;
        do_reset();
        chk("rst_req", req, 1'b0);
        chk("rst_vec", vec, 5'd0);
        chk("rst_intx", intx, 1'b0);
        chk("rst_pend", pend, 8'h00);

        for (int i = 0; i < 8; i++) run_rec(recs[i]);

        // rise on source 4 in its own grant cycle
        do_reset(); en = 1'b1; width = 3'd3;
        pulse(8'h10); step();
        chk("gr_rise_vec", vec, 5'd4);
        grant = 1'b1; intr = 8'h10; step(); grant = 1'b0; intr = '0;
        chk("gr_rise_drop", req, 1'b0);
        chk("gr_rise_pend_kept", pend, 8'h10);
        step();
        chk("gr_rise_second_req", req, 1'b1);
        chk("gr_rise_second_vec", vec, 5'd4);
        grant = 1'b1; step(); grant = 1'b0;
        chk("gr_rise_cleared", pend, 8'h00);

        // msi_width change while a request is in flight
        do_reset(); en = 1'b1; width = 3'd3;
        pulse(8'h80); step();
        chk("inflight_vec_a", vec, 5'd7);
        width = 3'd0; step();
        chk("inflight_vec_b", vec, 5'd7);
        chk("inflight_req", req, 1'b1);
        grant = 1'b1; step(); grant = 1'b0;
        pulse(8'h80); step();
        chk("width0_req", req, 1'b1);
        chk("width0_vec", vec, 5'd0);
        grant = 1'b1; step(); grant = 1'b0;

        // enable dropped during REQ, then grant while idle
        do_reset(); en = 1'b1; width = 3'd3;
        pulse(8'h40); step();
        chk("wd_req_up", req, 1'b1);
        en = 1'b0; step();
        chk("wd_withdrawn", req, 1'b0);
        chk("wd_pend_cleared", pend, 8'h00);
        en = 1'b1; step(); step();
        chk("wd_no_rereq", req, 1'b0);
        grant = 1'b1; step(); grant = 1'b0;
        chk("idle_grant_ignored", req, 1'b0);

        // legacy INTx
        do_reset(); en = 1'b0;
        intr = 8'h02;
        chk("intx_lag", intx, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("intx_high", intx, 1'b1);
        end
        chk("intx_no_req", req, 1'b0);
        chk("intx_no_pend", pend, 8'h00);
        intr = '0; step();
        chk("intx_low", intx, 1'b0);
        intr = 8'h02; step();
        chk("intx_again", intx, 1'b1);
        en = 1'b1; step();
        chk("intx_off_enabled", intx, 1'b0);
        chk("intx_no_pend_level", pend, 8'h00);
        intr = '0; step();

        // repeat instance: source 2 held high after its grant
        step(); r_rst = 1'b0;
        r_intr = 32'h4; step();
        chk("rep_pend", r_pend, 32'h4);
        step();
        chk("rep_req1", r_req, 1'b1);
        chk("rep_vec1", r_vec, 5'd2);
        r_grant = 1'b1; step(); r_grant = 1'b0;
        chk("rep_drop", r_req, 1'b0);
        chk("rep_pend_clr", r_pend, 32'h0);
        cnt = 0;
        while (!r_req && cnt < 40) begin
            step(); cnt++;
        end
        chk("rep_reraised", r_req, 1'b1);
        chk("rep_delay_window", (cnt >= 16 && cnt <= 19), 1'b1);
        chk("rep_vec2", r_vec, 5'd2);
        r_intr = '0; r_grant = 1'b1; step(); r_grant = 1'b0;

        // folding with 32 sources
        r_width = 3'd6; r_intr = 32'h0010_0000; step(); r_intr = '0; step();
        chk("fold_w6_vec", r_vec, 5'd20);
        r_grant = 1'b1; step(); r_grant = 1'b0;
        r_width = 3'd4; r_intr = 32'h0010_0000; step(); r_intr = '0; step();
        chk("fold_w4_vec", r_vec, 5'd4);
        r_grant = 1'b1; step(); r_grant = 1'b0;

        // reset in the middle of a request
        r_width = 3'd5; r_intr = 32'h0000_0600; step(); r_intr = '0; step();
        chk("midrst_req_up", r_req, 1'b1);
        chk("midrst_vec_up", r_vec, 5'd9);
        r_rst = 1'b1; step();
        chk("midrst_req", r_req, 1'b0);
        chk("midrst_vec", r_vec, 5'd0);
        chk("midrst_pend", r_pend, 32'h0);
        chk("midrst_intx", r_intx, 1'b0);
        r_rst = 1'b0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
